mole_round_scheduler: RTL and testbench
=======================================

Name: mole_round_scheduler

Overview:
Game-round sequencer for the whack-a-mole board. Decides which of the 9 holes lights, for how long, and when the next one spawns. Scores hits, counts misses against a life budget, shrinks the mole window as the score rises, and ends the round.
It sits between the LFSR and button debouncers (inputs) and the LEDR/HEX drivers (outputs), replacing ad-hoc LED timing in the top level.

Parameters:
N_HOLES, 9, number of mole LEDs/buttons
INIT_WINDOW, 100000000, initial mole-up time in cycles (2 s at 50 MHz)
STEP, 2500000, window reduction per hit (50 ms)
MIN_WINDOW, 25000000, floor for window
GAP_CYCLES, 25000000, dark time between moles
LIVES, 3, misses allowed per round (1..3)
SCORE_MAX, 99, score at which the round ends as a win

Ports:
cin  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; begins a round from IDLE or OVER
hit  in  9  one-cycle debounced button pulses, bit i = hole i
rnd  in  4  free-running LFSR value
led  out  9  one-hot mole LED, 0 when no mole is up
score  out  7  binary score 0..SCORE_MAX
lives  out  2  remaining lives
window  out  32  current mole-up time in cycles
busy  out  1  high in GAP or UP
game_over  out  1  high in OVER
win  out  1  high in OVER when score reached SCORE_MAX

Behaviour:
- One clock (cin); reset is synchronous, active-high (rst). All state changes occur on posedge cin.
- Reset values: state IDLE, led 0, score 0, lives LIVES, window INIT_WINDOW, counter 0, prev_hole 0, game_over 0, win 0, busy 0. rst overrides every other input in the same cycle, including mid-round.
- States: IDLE, GAP, UP, OVER. All outputs are registered.
- IDLE: start -> GAP next cycle; score 0, lives LIVES, window INIT_WINDOW, counter 0.
- GAP: counter increments each cycle. When counter == GAP_CYCLES-1:
  - hole = rnd mod 9; if hole == prev_hole, hole = (hole+1) mod 9.
  - Latch hole into prev_hole, clear counter, go to UP. led = one-hot(hole) from the first UP cycle.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- UP: counter increments each cycle.
  - Hit: hit[hole] == 1. Score +1 and window = max(window - STEP, MIN_WINDOW), both visible next cycle. led 0 next cycle, counter cleared. If the new score == SCORE_MAX, go to OVER with win = 1; otherwise go to GAP.
  - Timeout: counter == window-1 with no hit. lives -1, led 0, counter cleared. If the new lives == 0, go to OVER with win = 0; otherwise go to GAP. UP lasts at most window cycles.
  - Hit and timeout in the same cycle: the hit wins and no life is lost.
  - hit bits other than hole are ignored. Multiple hit bits set at once: only hit[hole] matters.
  - window changes take effect from the next UP period; the current UP compares against the registered value.
- OVER: led 0, game_over 1; score, lives and win hold. start -> same initialisation as from IDLE, go to GAP; win and game_over clear next cycle.
- start in GAP or UP is ignored.
- Width rules: window and counter are 32-bit unsigned. The subtraction saturates at MIN_WINDOW and never underflows. score saturates at SCORE_MAX and lives saturates at 0.
- busy = (state == GAP or UP).

Test Plan:
All scenarios use overrides INIT_WINDOW=20, STEP=4, MIN_WINDOW=8, GAP_CYCLES=5, LIVES=3, SCORE_MAX=99.
1. Spawn timing: rst, then start at cycle 0, rnd=4 held -> busy at cycle 1; led=9'b000010000 from cycle 6; led 0 at cycle 26 after a 20-cycle timeout; lives=2.
2. Hit: in UP on hole 4, pulse hit[4] on the 3rd UP cycle -> next cycle led 0, score 1, window 16, state GAP. Pulse hit[3] instead -> ignored, no score change.
3. Repeat avoidance and window floor: rnd=4 on two consecutive spawns -> second mole lights hole 5. Five hits in a row -> window 16, 12, 8, 8, 8.
4. Simultaneous hit and timeout: hit[hole] on the cycle counter == window-1 -> score +1, lives unchanged.
5. Game over: three timeouts -> lives 0, game_over 1, win 0, led 0. start while in OVER -> score 0, lives 3, window 20, busy 1 next cycle.
6. Reset mid-operation: rst asserted mid-UP with score 7 -> next cycle IDLE, led 0, score 0, lives 3, window 20. start pulsed during GAP -> no effect.

Source files
------------

// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: whack-a-mole round sequencer.
// Chooses which hole lights, keeps it up for the current window, scores hits,
// charges misses against a life budget, shrinks the window as the score rises,
// and ends the round on a win (SCORE_MAX) or when lives run out.
// Ports:
//   cin        clock
//   rst        synchronous active-high reset
//   start      one-cycle pulse, begins a round from IDLE or OVER
//   hit        debounced button pulses, bit i = hole i
//   rnd        free-running LFSR value used to pick the next hole
//   led        one-hot mole LED, 0 when no mole is up
//   score      binary score 0..SCORE_MAX
//   lives      remaining lives
//   window     current mole-up time in cycles
//   busy       high in GAP or UP
//   game_over  high in OVER
//   win        high in OVER when the round ended at SCORE_MAX
module mole_round_scheduler #(
  parameter int N_HOLES     = 9,
  parameter int INIT_WINDOW = 100000000,
  parameter int STEP        = 2500000,
  parameter int MIN_WINDOW  = 25000000,
  parameter int GAP_CYCLES  = 25000000,
  parameter int LIVES       = 3,
  parameter int SCORE_MAX   = 99
) (
  input  logic               cin,
  input  logic               rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] hit,
  input  logic [3:0]         rnd,
  output logic [N_HOLES-1:0] led,
  output logic [6:0]         score,
  output logic [1:0]         lives,
  output logic [31:0]        window,
  output logic               busy,
  output logic               game_over,
  output logic               win
);

  localparam int HW = $clog2(N_HOLES);

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

  state_t             state_q, state_d;
  logic [N_HOLES-1:0] led_q, led_d;
  logic [6:0]         score_q, score_d;
  logic [1:0]         lives_q, lives_d;
  logic [31:0]        window_q, window_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [HW-1:0]      prev_q, prev_d;
  logic               win_q, win_d;

  logic [HW-1:0] hole_raw, hole_nxt;
  logic [6:0]    score_inc;
  logic [1:0]    lives_dec;
  logic [31:0]   window_dec;

  // Never light the same hole twice in a row: bump to the next hole on repeat.
  always_comb begin
    hole_raw = HW'(32'(rnd) % N_HOLES);
    hole_nxt = hole_raw;
    if (hole_raw == prev_q)
      hole_nxt = (hole_raw == HW'(N_HOLES-1)) ? '0 : hole_raw + HW'(1);
  end

  // Saturating updates; the window compare avoids any underflow below the floor.
  assign score_inc  = (score_q == 7'(SCORE_MAX)) ? score_q : score_q + 7'd1;
  assign lives_dec  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
  assign window_dec = (window_q >= 32'(MIN_WINDOW) + 32'(STEP)) ?
                      window_q - 32'(STEP) : 32'(MIN_WINDOW);

  always_comb begin
    state_d  = state_q;
    led_d    = led_q;
    score_d  = score_q;
    lives_d  = lives_q;
    window_d = window_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    win_d    = win_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        led_d = '0;
        if (start) begin
          state_d  = S_GAP;
          score_d  = '0;
          lives_d  = 2'(LIVES);
          window_d = 32'(INIT_WINDOW);
          cnt_d    = '0;
          win_d    = 1'b0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == 32'(GAP_CYCLES - 1)) begin
          prev_d           = hole_nxt;
          cnt_d            = '0;
          led_d            = '0;
          led_d[hole_nxt]  = 1'b1;
          state_d          = S_UP;
        end
      end
      S_UP: begin
        cnt_d = cnt_q + 32'd1;
        // A hit on the final window cycle still counts as a hit.
        if (hit[prev_q]) begin
          score_d  = score_inc;
          window_d = window_dec;
          led_d    = '0;
          cnt_d    = '0;
          if (score_inc == 7'(SCORE_MAX)) begin
            state_d = S_OVER;
            win_d   = 1'b1;
          end else begin
            state_d = S_GAP;
          end
        end else if (cnt_q == window_q - 32'd1) begin
          lives_d = lives_dec;
          led_d   = '0;
          cnt_d   = '0;
          state_d = (lives_dec == 2'd0) ? S_OVER : S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      state_q  <= S_IDLE;
      led_q    <= '0;
      score_q  <= '0;
      lives_q  <= 2'(LIVES);
      window_q <= 32'(INIT_WINDOW);
      cnt_q    <= '0;
      prev_q   <= '0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      led_q    <= led_d;
      score_q  <= score_d;
      lives_q  <= lives_d;
      window_q <= window_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      win_q    <= win_d;
    end
  end

  assign led       = led_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign window    = window_q;
  assign busy      = (state_q == S_GAP) || (state_q == S_UP);
  assign game_over = (state_q == S_OVER);
  assign win       = win_q;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Testbench for mole_round_scheduler with small timing overrides
// (INIT_WINDOW=20, STEP=4, MIN_WINDOW=8, GAP_CYCLES=5, LIVES=3, SCORE_MAX=99).
// A vector table drives one cycle of inputs, idles for the remaining cycles,
// then compares every output; hand-written sequences cover start-ignore,
// mid-round reset and the win at SCORE_MAX.
module tb_mole_round_scheduler;

  logic       cin, rst, start;
  logic [8:0] hit;
  logic [3:0] rnd;
  logic [8:0] led;
  logic [6:0] score;
  logic [1:0] lives;
  logic [31:0] window;
  logic       busy, game_over, win;

  int nvec = 0;
  int nerr = 0;

  // bench-side model state for the hand-written sequences
  int        prev_h;
  int        m_score, m_lives;
  logic [31:0] m_w;

  mole_round_scheduler #(
    .N_HOLES(9), .INIT_WINDOW(20), .STEP(4), .MIN_WINDOW(8),
    .GAP_CYCLES(5), .LIVES(3), .SCORE_MAX(99)
  ) dut (
    .cin(cin), .rst(rst), .start(start), .hit(hit), .rnd(rnd),
    .led(led), .score(score), .lives(lives), .window(window),
    .busy(busy), .game_over(game_over), .win(win)
  );

  initial cin = 1'b0;
  always #5 cin = ~cin;

  typedef struct {
    logic        r;
    logic        s;
    logic [8:0]  h;
    logic [3:0]  rn;
    int          n;
    logic [8:0]  led;
    logic [6:0]  sc;
    logic [1:0]  lv;
    logic [31:0] w;
    logic        b, g, wn;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic r, logic s, logic [8:0] h, logic [3:0] rn, int n,
                              logic [8:0] el, logic [6:0] sc, logic [1:0] lv,
                              logic [31:0] w, logic b, logic g, logic wn);
    vec_t v;
    v.r = r; v.s = s; v.h = h; v.rn = rn; v.n = n;
    v.led = el; v.sc = sc; v.lv = lv; v.w = w; v.b = b; v.g = g; v.wn = wn;
    return v;
  endfunction

  task automatic check(string nm, logic [8:0] el, logic [6:0] es, logic [1:0] elv,
                       logic [31:0] ew, logic eb, logic eg, logic ewn);
    nvec++;
    if ({led, score, lives, window, busy, game_over, win} !==
        {el, es, elv, ew, eb, eg, ewn}) begin
      nerr++;
      $display("FAIL %s: got led=%b score=%0d lives=%0d window=%0d busy=%b go=%b win=%b, exp led=%b score=%0d lives=%0d window=%0d busy=%b go=%b win=%b",
               nm, led, score, lives, window, busy, game_over, win,
               el, es, elv, ew, eb, eg, ewn);
    end
  endtask

  function automatic int next_hole(logic [3:0] r);
    int h;
    h = int'(r) % 9;
    if (h == prev_h) h = (h + 1) % 9;
    return h;
  endfunction

  // GAP of 5 edges then the mole must be up on the predicted hole.
  task automatic spawn(logic [3:0] r, bit ps);
    int h;
    rnd = r;
    h = next_hole(r);
    for (int k = 0; k < 5; k++) begin
      if (k == 0 && ps) start = 1'b1;
      @(negedge cin);
      start = 1'b0;
    end
    check("spawn", 9'b1 << h, 7'(m_score), 2'(m_lives), m_w, 1'b1, 1'b0, 1'b0);
    prev_h = h;
  endtask

  task automatic spawn_hit(logic [3:0] r, bit ps);
    spawn(r, ps);
    hit = 9'b1 << prev_h;
    @(negedge cin);
    hit = '0;
    m_score++;
    m_w = (m_w >= 32'd12) ? m_w - 32'd4 : 32'd8;
    check("hit", 9'd0, 7'(m_score), 2'(m_lives), m_w,
          m_score != 99, m_score == 99, m_score == 99);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hit = '0; rnd = '0;

    //               r  s  hit     rnd  n   led          sc lv w   b g wn
    tv.push_back(mk(1, 0, 9'h000, 4,  1, 9'b000000000, 0, 3, 20, 0,0,0)); // reset
    tv.push_back(mk(0, 1, 9'h000, 4,  1, 9'b000000000, 0, 3, 20, 1,0,0)); // busy at cycle 1
    tv.push_back(mk(0, 0, 9'h000, 4,  4, 9'b000000000, 0, 3, 20, 1,0,0)); // still dark at cycle 5
    tv.push_back(mk(0, 0, 9'h000, 4,  1, 9'b000010000, 0, 3, 20, 1,0,0)); // hole 4 at cycle 6
    tv.push_back(mk(0, 0, 9'h000, 4, 19, 9'b000010000, 0, 3, 20, 1,0,0)); // last UP cycle
    tv.push_back(mk(0, 0, 9'h000, 4,  1, 9'b000000000, 0, 2, 20, 1,0,0)); // timeout at cycle 26
    tv.push_back(mk(0, 0, 9'h000, 4,  5, 9'b000100000, 0, 2, 20, 1,0,0)); // repeat -> hole 5
    tv.push_back(mk(0, 0, 9'h008, 4,  1, 9'b000100000, 0, 2, 20, 1,0,0)); // wrong button ignored
    tv.push_back(mk(0, 0, 9'h020, 4,  1, 9'b000000000, 1, 2, 16, 1,0,0)); // hit, 3rd UP cycle
    tv.push_back(mk(0, 0, 9'h000, 13, 5, 9'b000010000, 1, 2, 16, 1,0,0)); // 13%9=4
    tv.push_back(mk(0, 0, 9'h010, 13, 1, 9'b000000000, 2, 2, 12, 1,0,0));
    tv.push_back(mk(0, 0, 9'h000, 13, 5, 9'b000100000, 2, 2, 12, 1,0,0)); // repeat 4 -> 5
    tv.push_back(mk(0, 0, 9'h020, 13, 1, 9'b000000000, 3, 2,  8, 1,0,0));
    tv.push_back(mk(0, 0, 9'h000, 0,  5, 9'b000000001, 3, 2,  8, 1,0,0));
    tv.push_back(mk(0, 0, 9'h001, 0,  1, 9'b000000000, 4, 2,  8, 1,0,0)); // floor
    tv.push_back(mk(0, 0, 9'h000, 0,  5, 9'b000000010, 4, 2,  8, 1,0,0)); // repeat 0 -> 1
    tv.push_back(mk(0, 0, 9'h002, 0,  1, 9'b000000000, 5, 2,  8, 1,0,0)); // floor holds
    tv.push_back(mk(0, 0, 9'h000, 15, 5, 9'b001000000, 5, 2,  8, 1,0,0)); // 15%9=6
    tv.push_back(mk(0, 0, 9'h000, 15, 7, 9'b001000000, 5, 2,  8, 1,0,0)); // counter == window-1
    tv.push_back(mk(0, 0, 9'h040, 15, 1, 9'b000000000, 6, 2,  8, 1,0,0)); // hit beats timeout
    tv.push_back(mk(0, 0, 9'h000, 2,  5, 9'b000000100, 6, 2,  8, 1,0,0));
    tv.push_back(mk(0, 0, 9'h000, 2,  8, 9'b000000000, 6, 1,  8, 1,0,0)); // 8-cycle timeout
    tv.push_back(mk(0, 0, 9'h000, 2,  5, 9'b000001000, 6, 1,  8, 1,0,0)); // repeat 2 -> 3
    tv.push_back(mk(0, 0, 9'h000, 2,  8, 9'b000000000, 6, 0,  8, 0,1,0)); // last life lost
    tv.push_back(mk(0, 0, 9'h000, 2,  3, 9'b000000000, 6, 0,  8, 0,1,0)); // OVER holds
    tv.push_back(mk(0, 0, 9'h1FF, 2,  1, 9'b000000000, 6, 0,  8, 0,1,0)); // hits ignored in OVER
    tv.push_back(mk(0, 1, 9'h000, 2,  1, 9'b000000000, 0, 3, 20, 1,0,0)); // restart from OVER

    foreach (tv[i]) begin
      rst = tv[i].r; start = tv[i].s; hit = tv[i].h; rnd = tv[i].rn;
      @(negedge cin);
      rst = 1'b0; start = 1'b0; hit = '0;
      repeat (tv[i].n - 1) @(negedge cin);
      check($sformatf("vec%0d", i), tv[i].led, tv[i].sc, tv[i].lv, tv[i].w,
            tv[i].b, tv[i].g, tv[i].wn);
    end

    // Round in progress: GAP counter at 0, last hole was 3.
    prev_h = 3; m_score = 0; m_lives = 3; m_w = 32'd20;

    // Seven hits; start pulsed in the first GAP must not restart it.
    for (int i = 0; i < 7; i++) spawn_hit(4'((i * 5 + 1) % 16), i == 0);

    // start during UP is ignored, then reset mid-UP with score 7.
    spawn(4'd9, 1'b0);
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    check("up_start_ignored", 9'b1 << prev_h, 7'd7, 2'd3, m_w, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge cin);
    rst = 1'b0;
    check("mid_reset", 9'd0, 7'd0, 2'd3, 32'd20, 1'b0, 1'b0, 1'b0);
    @(negedge cin);
    check("idle_hold", 9'd0, 7'd0, 2'd3, 32'd20, 1'b0, 1'b0, 1'b0);
    prev_h = 0; m_score = 0; m_lives = 3; m_w = 32'd20;

    // Play to SCORE_MAX; the final hit must end the round as a win.
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    check("start_idle", 9'd0, 7'd0, 2'd3, 32'd20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) spawn_hit(4'((i * 7 + 3) % 16), 1'b0);
    repeat (3) @(negedge cin);
    check("win_hold", 9'd0, 7'd99, 2'd3, 32'd8, 1'b0, 1'b1, 1'b1);
    start = 1'b1;
    @(negedge cin);
    start = 1'b0;
    check("restart_after_win", 9'd0, 7'd0, 2'd3, 32'd20, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
